// File: rtl/pc_fetch_unit_pkg.sv
// Shared word width, boot/exception vectors and fetch FSM encodings
// for the instruction fetch front end.
package pc_fetch_unit_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD    = '0;
    localparam logic [WORD_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC selection: branch target formation and redirect priority
// (exception > eret > taken branch > sequential).
module next_pc_sel
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned  W          = WORD_WIDTH,
    parameter logic [W-1:0] EXC_VECTOR = W'(pc_fetch_unit_pkg::EXC_VECTOR),
    parameter int unsigned  INST_BYTES = 4
) (
    input  logic [W-1:0] pc,
    input  logic [W-1:0] inst_pc,
    input  logic         stall,
    input  logic         exc_take,
    input  logic         eret,
    input  logic [W-1:0] epc,
    input  logic         can_branch,
    input  logic         targ_else_offset,
    input  logic         branch_take,
    input  logic         pc_addr_src_reg,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] imm,
    output logic         redirect,
    output logic [W-1:0] next_pc
);

    logic [W-1:0] src;
    logic [W-1:0] target;
    logic         branch_go;

    always_comb begin
        src       = pc_addr_src_reg ? rs_val : imm;
        target    = targ_else_offset ? src : (inst_pc + src + W'(INST_BYTES));
        // Exceptions and eret redirect even while stalled; branches do not.
        branch_go = can_branch && branch_take && !stall;
        redirect  = exc_take || eret || branch_go;
        if (exc_take)
            next_pc = EXC_VECTOR;
        else if (eret)
            next_pc = epc;
        else if (branch_go)
            next_pc = target;
        else
            next_pc = pc + W'(INST_BYTES);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, presents the
// returned instruction, holds it under stall and handles redirects/kills.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned  W            = WORD_WIDTH,
    parameter logic [W-1:0] RESET_VECTOR = W'(pc_fetch_unit_pkg::RESET_VECTOR),
    parameter logic [W-1:0] EXC_VECTOR   = W'(pc_fetch_unit_pkg::EXC_VECTOR),
    parameter int unsigned  INST_BYTES   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         exc_take,
    input  logic         eret,
    input  logic [W-1:0] epc,
    input  logic         can_branch,
    input  logic         targ_else_offset,
    input  logic         branch_take,
    input  logic         pc_addr_src_reg,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] imm,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] pc,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    output logic         inst_valid
);

    logic [1:0]   state;
    logic         kill;
    logic [W-1:0] kill_pc;
    logic         redirect;
    logic [W-1:0] next_pc;

    next_pc_sel #(
        .W          (W),
        .EXC_VECTOR (EXC_VECTOR),
        .INST_BYTES (INST_BYTES)
    ) u_next_pc_sel (
        .pc               (pc),
        .inst_pc          (inst_pc),
        .stall            (stall),
        .exc_take         (exc_take),
        .eret             (eret),
        .epc              (epc),
        .can_branch       (can_branch),
        .targ_else_offset (targ_else_offset),
        .branch_take      (branch_take),
        .pc_addr_src_reg  (pc_addr_src_reg),
        .rs_val           (rs_val),
        .imm              (imm),
        .redirect         (redirect),
        .next_pc          (next_pc)
    );

    assign imem_req  = (state == S_REQ) && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_BOOT;
            pc         <= RESET_VECTOR;
            inst       <= W'(ZERO_WORD);
            inst_pc    <= W'(ZERO_WORD);
            inst_valid <= 1'b0;
            kill       <= 1'b0;
            kill_pc    <= W'(ZERO_WORD);
        end else begin
            case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (redirect) begin
                        inst_valid <= 1'b0;
                        // Pending request stays on the bus; its data is dropped later.
                        if (imem_gnt) begin
                            pc   <= next_pc;
                            kill <= 1'b0;
                        end else begin
                            kill    <= 1'b1;
                            kill_pc <= next_pc;
                        end
                    end else if (imem_gnt && kill) begin
                        pc         <= kill_pc;
                        kill       <= 1'b0;
                        inst_valid <= 1'b0;
                    end else if (stall) begin
                        if (inst_valid)
                            state <= S_HOLD;
                    end else if (imem_gnt) begin
                        inst       <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        pc         <= next_pc;
                    end else begin
                        inst_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // pc already holds the sequential successor of the held instruction.
                    if (redirect) begin
                        pc         <= next_pc;
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end else if (!stall) begin
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed per-cycle stimulus pushes the
// expected request addresses and instructions; a negedge monitor pops and checks.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        exc_take = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'h0;
    logic        can_branch = 1'b0;
    logic        targ_else_offset = 1'b0;
    logic        branch_take = 1'b0;
    logic        pc_addr_src_reg = 1'b0;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] imm = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_hs[$];
    logic [31:0] exp_inst[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    pc_fetch_unit #(
        .W            (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0180),
        .INST_BYTES   (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .exc_take         (exc_take),
        .eret             (eret),
        .epc              (epc),
        .can_branch       (can_branch),
        .targ_else_offset (targ_else_offset),
        .branch_take      (branch_take),
        .pc_addr_src_reg  (pc_addr_src_reg),
        .rs_val           (rs_val),
        .imm              (imm),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rdata       (imem_rdata),
        .pc               (pc),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_valid       (inst_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // Expect a granted request at address a; keep=1 if its data must be presented.
    task automatic hs(input logic [31:0] a, input bit keep);
        exp_hs.push_back(a);
        if (keep)
            exp_inst.push_back(a);
    endtask

    initial begin
        logic        prev_iv;
        logic [31:0] prev_ipc;
        logic [31:0] e;
        prev_iv  = 1'b0;
        prev_ipc = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (imem_req && imem_gnt) begin
                    if (exp_hs.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL hs_extra: got request %h, required none", imem_addr);
                    end else begin
                        e = exp_hs.pop_front();
                        chk("hs_addr", imem_addr, e);
                    end
                end
                if (inst_valid && (!prev_iv || inst_pc != prev_ipc)) begin
                    if (exp_inst.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL inst_extra: got inst_pc %h, required none", inst_pc);
                    end else begin
                        e = exp_inst.pop_front();
                        chk("inst_pc", inst_pc, e);
                        chk("inst_data", inst, mem_word(e));
                    end
                end
                prev_iv  = inst_valid;
                prev_ipc = inst_pc;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk_b("rst_valid", inst_valid, 1'b0);
        chk_b("rst_req", imem_req, 1'b0);
        rst = 1'b0;

        for (int c = 1; c <= 36; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            stall = 1'b0; exc_take = 1'b0; eret = 1'b0;
            can_branch = 1'b0; branch_take = 1'b0;
            targ_else_offset = 1'b0; pc_addr_src_reg = 1'b0;
            imem_gnt = !((c >= 16 && c <= 20) || c >= 33);
            case (c)
                1: chk_b("boot_req", imem_req, 1'b0);
                2: begin
                    chk("c2_addr", imem_addr, 32'h0);
                    chk_b("c2_req", imem_req, 1'b1);
                    chk_b("c2_valid", inst_valid, 1'b0);
                    hs(32'h0, 1);
                end
                3: begin
                    chk_b("c3_first_valid", inst_valid, 1'b1);
                    chk("c3_addr", imem_addr, 32'h4);
                    hs(32'h4, 1);
                end
                4: begin chk("c4_addr", imem_addr, 32'h8); hs(32'h8, 1); end
                5: hs(32'hC, 1);
                6: hs(32'h10, 1);
                7: begin
                    chk("c7_inst_pc", inst_pc, 32'h10);
                    can_branch = 1'b1; branch_take = 1'b1; imm = 32'h20;
                    hs(32'h14, 0);
                end
                8: begin
                    chk("off_branch_addr", imem_addr, 32'h34);
                    chk_b("off_branch_valid", inst_valid, 1'b0);
                    hs(32'h34, 1);
                end
                9: begin
                    can_branch = 1'b1; branch_take = 1'b1;
                    targ_else_offset = 1'b1; pc_addr_src_reg = 1'b1; rs_val = 32'h400;
                    hs(32'h38, 0);
                end
                10: begin
                    chk("abs_branch_addr", imem_addr, 32'h400);
                    chk_b("abs_branch_valid", inst_valid, 1'b0);
                    hs(32'h400, 1);
                end
                11: begin stall = 1'b1; hs(32'h404, 0); end
                12, 13: begin
                    stall = 1'b1;
                    chk_b("hold_req", imem_req, 1'b0);
                    chk_b("hold_valid", inst_valid, 1'b1);
                    chk("hold_inst_pc", inst_pc, 32'h400);
                    chk("hold_inst", inst, mem_word(32'h400));
                end
                14: chk_b("hold_exit_req", imem_req, 1'b0);
                15: begin
                    chk("resume_addr", imem_addr, 32'h404);
                    chk_b("resume_req", imem_req, 1'b1);
                    chk_b("resume_valid", inst_valid, 1'b0);
                    hs(32'h404, 1);
                end
                17: exc_take = 1'b1;
                18, 19, 20: begin
                    chk("kill_hold_addr", imem_addr, 32'h408);
                    chk_b("kill_hold_req", imem_req, 1'b1);
                    chk_b("kill_valid", inst_valid, 1'b0);
                end
                21: begin chk("kill_gnt_addr", imem_addr, 32'h408); hs(32'h408, 0); end
                22: begin
                    chk("exc_addr", imem_addr, 32'h180);
                    chk_b("exc_drop_valid", inst_valid, 1'b0);
                    hs(32'h180, 1);
                end
                23: begin
                    stall = 1'b1; exc_take = 1'b1; eret = 1'b1; epc = 32'h200;
                    hs(32'h184, 0);
                end
                24: begin chk("exc_wins_addr", imem_addr, 32'h180); hs(32'h180, 1); end
                25: begin eret = 1'b1; epc = 32'h200; hs(32'h184, 0); end
                26: begin chk("eret_addr", imem_addr, 32'h200); hs(32'h200, 1); end
                27: begin stall = 1'b1; hs(32'h204, 0); end
                28: begin
                    stall = 1'b1; eret = 1'b1; epc = 32'h300;
                    chk_b("hold2_req", imem_req, 1'b0);
                    chk("hold2_inst_pc", inst_pc, 32'h200);
                end
                29: begin
                    chk("hold_redir_addr", imem_addr, 32'h300);
                    chk_b("hold_redir_valid", inst_valid, 1'b0);
                    hs(32'h300, 1);
                end
                30: begin
                    can_branch = 1'b1; branch_take = 1'b1;
                    targ_else_offset = 1'b1; pc_addr_src_reg = 1'b1; rs_val = 32'hFFFF_FFFC;
                    hs(32'h304, 0);
                end
                31: begin chk("top_addr", imem_addr, 32'hFFFF_FFFC); hs(32'hFFFF_FFFC, 1); end
                32: begin chk("wrap_addr", imem_addr, 32'h0); hs(32'h0, 1); end
                34: chk_b("idle_valid", inst_valid, 1'b0);
                default: ;
            endcase
        end

        chk("hs_drain", 32'(exp_hs.size()), 32'h0);
        chk("inst_drain", 32'(exp_inst.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
